pwm_sched: RTL and testbench
============================

PWM_SCHED -- requirements
Module: pwm_sched

Interface
REQ-001 Parameters, one per line: name, default, meaning:
 NPWM  12  channel count, 1..64
 PWM_BITS  26  period/on-time counter width, 8..32
 CMD_BITS  8  command code width
 CMD_CONFIG_PWM  2  config command code
 CMD_SCHEDULE_PWM  3  schedule command code
 CMD_PWM_STATUS  4  status-query command code
REQ-002 Ports, one per line: name, direction, width, meaning:
 clk  in  1  sole clock, rising edge
 rst_n  in  1  reset, asynchronous, active-low
 systime  in  32  free-running system time, wraps
 arg_data  in  32  current command argument word
 arg_advance  out  1  constant 1; one argument consumed per clk
 cmd  in  CMD_BITS  command code, valid with cmd_ready
 cmd_ready  in  1  command present, first arg (channel) on arg_data
 cmd_done  out  1  one-cycle pulse, command finished
 param_data  out  32  status reply word
 param_write  out  1  one-cycle strobe, param_data valid
 pwm  out  NPWM  channel outputs

Function
REQ-003 Command FSM states: IDLE, CFG_PERIOD, CFG_ON, CFG_FLAGS, CFG_DUR, SCH_TIME, SCH_ON, STATUS; cmd_ready is sampled only in IDLE.
REQ-004 In IDLE with cmd_ready: latch channel = arg_data[$clog2(NPWM)-1:0]; CONFIG -> CFG_PERIOD; SCHEDULE -> SCH_TIME; STATUS -> STATUS; any other code -> cmd_done next cycle, stay in IDLE.
REQ-005 CONFIG args, one per cycle: period (PWM_BITS), on (PWM_BITS), flags (bit0 default level, bit1 invert), max_duration (32); cmd_done pulses the cycle after max_duration is taken.
REQ-006 A completed CONFIG clears the counter, pending schedule, late flag and duration of that channel and loads on into both the active and shadow on-time registers.
REQ-007 SCHEDULE args: time (32), on (PWM_BITS); the slot is marked pending and cmd_done pulses; a new SCHEDULE overwrites an existing pending slot without setting late.
REQ-008 STATUS: one cycle after entry, param_data = {active_on[23:0] zero-extended as needed, 5'b0, late, pending, pwm[ch]} and param_write=1; cmd_done pulses in the same cycle; late is cleared by the read.
REQ-009 Channel counter counts 0..period-1 and wraps; raw output = (cnt < active_on); final pwm = raw XOR invert, registered (1-cycle latency).
REQ-010 period==0: counter holds 0; raw output = (active_on != 0).
REQ-011 active_on >= period gives constant 1; active_on==0 gives constant 0; neither case shall produce a glitch pulse.
REQ-012 Schedule fires when $signed(systime - time) >= 0 (wrap-safe); on firing: shadow_on <= on, duration <= max_duration, pending cleared; late set when the difference is > 0.
REQ-013 shadow_on transfers to active_on only at the wrap cycle (cnt == period-1), or immediately when period <= 1.
REQ-014 Duration: when nonzero, decrements every clk; on the 1->0 transition shadow_on <= all-ones if default=1, else 0; max_duration==0 disables the timeout.
REQ-015 Schedule firing and duration expiry in the same cycle: firing wins.
REQ-016 CONFIG completion and schedule firing on the same channel in the same cycle: CONFIG wins.

Reset
REQ-017 rst_n low asynchronously forces pwm=0, cmd_done=0, param_write=0, param_data=0, FSM=IDLE, and all per-channel registers to 0; outputs stay constant 0 until configured.
REQ-018 rst_n deassertion is synchronised internally (2-flop) before state leaves reset; reset mid-command drops the command silently with no cmd_done.

Structure
REQ-019 Shared package pwm_pkg holds command codes, FSM state enum and the status-word bit positions.
REQ-020 One sub-module, pwm_channel (counter, shadow/active on-time, duration, schedule compare), instantiated NPWM times; the top level holds the command FSM only.

Verification
REQ-021 CONFIG ch0 period=10 on=3 flags=0 dur=0 -> pwm[0] high 3, low 7 clk, repeating.
REQ-022 SCHEDULE ch0 time=systime+50 on=7 -> change lands at the next wrap after systime reaches the target; no short or long pulse; late=0.
REQ-023 SCHEDULE with time=systime-5 -> applied next cycle, STATUS reply has late=1, a second STATUS has late=0.
REQ-024 CONFIG dur=100 default=1, then schedule on=2 -> after 100 clk, pwm constant 1 from the next wrap.
REQ-025 systime near 0xFFFFFFF0, schedule time=0x00000010 -> fires at the wrapped time, not immediately.
REQ-026 Assert rst_n low in CFG_ON -> pwm=0 at once, no cmd_done, next command accepted normally.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared command codes, command FSM states and status-word layout for pwm_sched
package pwm_pkg;
  localparam int CMD_CONFIG_PWM_DEF   = 2;
  localparam int CMD_SCHEDULE_PWM_DEF = 3;
  localparam int CMD_PWM_STATUS_DEF   = 4;
  localparam int ST_PWM     = 0;
  localparam int ST_PENDING = 1;
  localparam int ST_LATE    = 2;
  localparam int ST_ON_LSB  = 8;
  localparam int ST_ON_BITS = 24;
  typedef enum logic [2:0] {
    IDLE, CFG_PERIOD, CFG_ON, CFG_FLAGS, CFG_DUR, SCH_TIME, SCH_ON, STATUS
  } state_t;
  function automatic logic [31:0] status_word(input logic [ST_ON_BITS-1:0] on, input logic late,
                                              input logic pending, input logic pwm);
    status_word = '0;
    status_word[ST_ON_LSB +: ST_ON_BITS] = on;
    status_word[ST_LATE] = late;
    status_word[ST_PENDING] = pending;
    status_word[ST_PWM] = pwm;
  endfunction
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM channel with period counter, shadow/active on-time, timeout and timed schedule
//   clk, rst_n          clock and (already synchronised) async active-low reset
//   systime             free-running time used for the wrap-safe schedule compare
//   cfg, cfg_*          one-cycle config load: period, on-time, flags {invert, default}, max duration
//   sch, sch_time/on    one-cycle schedule load (overwrites any pending slot)
//   clr_late            status read, clears the late flag
//   pwm                 registered channel output
//   active_on/pending/late  status fields
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int PWM_BITS = 26
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         systime,
  input  logic                cfg,
  input  logic [PWM_BITS-1:0] cfg_period,
  input  logic [PWM_BITS-1:0] cfg_on,
  input  logic [1:0]          cfg_flags,
  input  logic [31:0]         cfg_dur,
  input  logic                sch,
  input  logic [31:0]         sch_time,
  input  logic [PWM_BITS-1:0] sch_on,
  input  logic                clr_late,
  output logic                pwm,
  output logic [PWM_BITS-1:0] active_on,
  output logic                pending,
  output logic                late
);
  logic [PWM_BITS-1:0] period, cnt, shadow_on, on_sch, shadow_nxt;
  logic [31:0] max_dur, dur, time_sch, diff;
  logic dflt, inv, fire, wrap, raw;
  always_comb begin
    diff = systime - time_sch;
    // sign of the wrapped difference decides "reached", so systime may wrap past the target
    fire = pending & ~diff[31];
    wrap = (period <= PWM_BITS'(1)) | (cnt == period - PWM_BITS'(1));
    // firing beats a timeout that expires in the same cycle
    shadow_nxt = fire ? on_sch : (dur == 32'd1) ? {PWM_BITS{dflt}} : shadow_on;
    raw = (period == '0) ? (active_on != '0) : (cnt < active_on);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pwm <= 1'b0;
      period <= '0;
      cnt <= '0;
      active_on <= '0;
      shadow_on <= '0;
      on_sch <= '0;
      time_sch <= '0;
      max_dur <= '0;
      dur <= '0;
      dflt <= 1'b0;
      inv <= 1'b0;
      pending <= 1'b0;
      late <= 1'b0;
    end else begin
      pwm <= raw ^ inv;
      if (sch) begin
        time_sch <= sch_time;
        on_sch <= sch_on;
      end
      if (cfg) begin
        period <= cfg_period;
        cnt <= '0;
        active_on <= cfg_on;
        shadow_on <= cfg_on;
        dflt <= cfg_flags[0];
        inv <= cfg_flags[1];
        max_dur <= cfg_dur;
        dur <= '0;
        pending <= 1'b0;
        late <= 1'b0;
      end else begin
        // on-time changes only land when the counter restarts, so no partial pulses
        cnt <= wrap ? '0 : cnt + PWM_BITS'(1);
        active_on <= wrap ? shadow_nxt : active_on;
        shadow_on <= shadow_nxt;
        dur <= fire ? max_dur : (dur != '0) ? dur - 32'd1 : dur;
        pending <= sch | (pending & ~fire);
        late <= (fire & (|diff)) | (late & ~clr_late);
      end
    end
endmodule

// File: rtl/pwm_sched.sv
// pwm_sched: command-driven scheduler for NPWM PWM channels
//   clk, rst_n                 clock, async active-low reset (deassertion synchronised)
//   systime                    free-running system time
//   arg_data / arg_advance     argument word stream, one word consumed every clk
//   cmd, cmd_ready, cmd_done   command code/valid, one-cycle completion pulse
//   param_data, param_write    status reply word and its strobe
//   pwm                        channel outputs
module pwm_sched
  import pwm_pkg::*;
#(
  parameter int NPWM             = 12,
  parameter int PWM_BITS         = 26,
  parameter int CMD_BITS         = 8,
  parameter int CMD_CONFIG_PWM   = CMD_CONFIG_PWM_DEF,
  parameter int CMD_SCHEDULE_PWM = CMD_SCHEDULE_PWM_DEF,
  parameter int CMD_PWM_STATUS   = CMD_PWM_STATUS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         systime,
  input  logic [31:0]         arg_data,
  output logic                arg_advance,
  input  logic [CMD_BITS-1:0] cmd,
  input  logic                cmd_ready,
  output logic                cmd_done,
  output logic [31:0]         param_data,
  output logic                param_write,
  output logic [NPWM-1:0]     pwm
);
  localparam int CH_W = (NPWM > 1) ? $clog2(NPWM) : 1;
  state_t state, state_nxt;
  logic [1:0] rst_q;
  logic rst_s, done_nxt, write_nxt, unused_on;
  logic [CH_W-1:0] ch;
  logic [PWM_BITS-1:0] period_r, on_r, on_sel;
  logic [1:0] flags_r;
  logic [31:0] time_r, on_ext;
  logic [PWM_BITS-1:0] act_on [NPWM];
  logic [NPWM-1:0] hit, pend, late;
  assign arg_advance = 1'b1;
  assign rst_s = rst_q[1];
  assign on_ext = 32'(on_sel);
  assign unused_on = ^on_ext[31:ST_ON_BITS];
  // reset asserts immediately but releases two clocks after rst_n rises
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_q <= '0;
    else rst_q <= {rst_q[0], 1'b1};
  always_comb begin
    state_nxt = state;
    done_nxt = 1'b0;
    write_nxt = 1'b0;
    case (state)
      IDLE: if (cmd_ready) begin
        state_nxt = (cmd == CMD_BITS'(CMD_CONFIG_PWM))   ? CFG_PERIOD :
                    (cmd == CMD_BITS'(CMD_SCHEDULE_PWM)) ? SCH_TIME :
                    (cmd == CMD_BITS'(CMD_PWM_STATUS))   ? STATUS : IDLE;
        done_nxt = (state_nxt == IDLE);
      end
      CFG_PERIOD: state_nxt = CFG_ON;
      CFG_ON:     state_nxt = CFG_FLAGS;
      CFG_FLAGS:  state_nxt = CFG_DUR;
      SCH_TIME:   state_nxt = SCH_ON;
      CFG_DUR, SCH_ON: begin
        state_nxt = IDLE;
        done_nxt = 1'b1;
      end
      STATUS: begin
        state_nxt = IDLE;
        done_nxt = 1'b1;
        write_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    on_sel = '0;
    for (int k = 0; k < NPWM; k++) on_sel = hit[k] ? act_on[k] : on_sel;
  end
  always_ff @(posedge clk or negedge rst_s)
    if (!rst_s) begin
      state <= IDLE;
      ch <= '0;
      period_r <= '0;
      on_r <= '0;
      flags_r <= '0;
      time_r <= '0;
      cmd_done <= 1'b0;
      param_write <= 1'b0;
      param_data <= '0;
    end else begin
      state <= state_nxt;
      cmd_done <= done_nxt;
      param_write <= write_nxt;
      if (state == IDLE && cmd_ready) ch <= arg_data[CH_W-1:0];
      if (state == CFG_PERIOD) period_r <= arg_data[PWM_BITS-1:0];
      if (state == CFG_ON) on_r <= arg_data[PWM_BITS-1:0];
      if (state == CFG_FLAGS) flags_r <= arg_data[1:0];
      if (state == SCH_TIME) time_r <= arg_data;
      if (write_nxt) param_data <= status_word(on_ext[ST_ON_BITS-1:0], |(hit & late), |(hit & pend), |(hit & pwm));
    end
  for (genvar i = 0; i < NPWM; i++) begin : g_ch
    assign hit[i] = (32'(ch) == i);
    pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk       (clk),
      .rst_n     (rst_s),
      .systime   (systime),
      .cfg       (state == CFG_DUR && hit[i]),
      .cfg_period(period_r),
      .cfg_on    (on_r),
      .cfg_flags (flags_r),
      .cfg_dur   (arg_data),
      .sch       (state == SCH_ON && hit[i]),
      .sch_time  (time_r),
      .sch_on    (arg_data[PWM_BITS-1:0]),
      .clr_late  (state == STATUS && hit[i]),
      .pwm       (pwm[i]),
      .active_on (act_on[i]),
      .pending   (pend[i]),
      .late      (late[i])
    );
  end
endmodule

// File: tb/tb_pwm_sched.sv
// tb_pwm_sched: randomized command stream checked cycle by cycle against a behavioural channel model
module tb_pwm_sched;
  localparam int NPWM = 12;
  localparam int unsigned ONES = 32'h03FF_FFFF;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] systime = '0;
  logic [31:0] arg_data = '0;
  logic arg_advance;
  logic [7:0] cmd = '0;
  logic cmd_ready = 1'b0;
  logic cmd_done;
  logic [31:0] param_data;
  logic param_write;
  logic [NPWM-1:0] pwm;
  always #5 clk = ~clk;
  pwm_sched dut (
    .clk(clk), .rst_n(rst_n), .systime(systime), .arg_data(arg_data), .arg_advance(arg_advance),
    .cmd(cmd), .cmd_ready(cmd_ready), .cmd_done(cmd_done), .param_data(param_data),
    .param_write(param_write), .pwm(pwm)
  );
  int checks = 0;
  int failures = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  int unsigned m_per[NPWM], m_cnt[NPWM], m_act[NPWM], m_sh[NPWM], m_son[NPWM];
  int unsigned m_maxd[NPWM], m_dur[NPWM], m_time[NPWM];
  bit m_dflt[NPWM], m_inv[NPWM], m_pend[NPWM], m_late[NPWM], m_pwm[NPWM];
  int ev_cfg = -1, ev_sch = -1, ev_rd = -1;
  int unsigned c_per, c_on, c_dur, s_time, s_on;
  bit [1:0] c_fl;
  bit exp_done = 0, exp_pw = 0, in_rst = 1;
  logic [31:0] exp_pd = '0;
  task automatic model_clear();
    for (int c = 0; c < NPWM; c++) begin
      m_per[c] = 0; m_cnt[c] = 0; m_act[c] = 0; m_sh[c] = 0; m_son[c] = 0;
      m_maxd[c] = 0; m_dur[c] = 0; m_time[c] = 0;
      m_dflt[c] = 0; m_inv[c] = 0; m_pend[c] = 0; m_late[c] = 0; m_pwm[c] = 0;
    end
  endtask
  // one rising edge of the reference: outputs from the old state, then the spec's update rules
  task automatic model_step();
    int unsigned d, nsh;
    bit fire, wrap;
    if (in_rst) begin
      model_clear();
      return;
    end
    if (ev_rd >= 0)
      exp_pd = ((m_act[ev_rd] & 32'h00FF_FFFF) << 8) | (32'(m_late[ev_rd]) << 2) |
               (32'(m_pend[ev_rd]) << 1) | 32'(m_pwm[ev_rd]);
    for (int c = 0; c < NPWM; c++) begin
      d = systime - m_time[c];
      fire = m_pend[c] && ($signed(d) >= 0);
      m_pwm[c] = ((m_per[c] == 0) ? (m_act[c] != 0) : (m_cnt[c] < m_act[c])) ^ m_inv[c];
      if (ev_cfg == c) begin
        m_per[c] = c_per; m_cnt[c] = 0; m_act[c] = c_on; m_sh[c] = c_on;
        m_dflt[c] = c_fl[0]; m_inv[c] = c_fl[1]; m_maxd[c] = c_dur; m_dur[c] = 0;
        m_pend[c] = 0; m_late[c] = 0;
      end else begin
        nsh = fire ? m_son[c] : (m_dur[c] == 1) ? (m_dflt[c] ? ONES : 0) : m_sh[c];
        wrap = (m_per[c] <= 1) || (m_cnt[c] == m_per[c] - 1);
        if (wrap) m_act[c] = nsh;
        m_sh[c] = nsh;
        m_cnt[c] = wrap ? 0 : m_cnt[c] + 1;
        m_dur[c] = fire ? m_maxd[c] : (m_dur[c] != 0) ? m_dur[c] - 1 : 0;
        if (fire && d != 0) m_late[c] = 1;
        else if (ev_rd == c) m_late[c] = 0;
        m_pend[c] = (ev_sch == c) || (m_pend[c] && !fire);
      end
      if (ev_sch == c) begin
        m_time[c] = s_time;
        m_son[c] = s_on;
      end
    end
  endtask
  function automatic logic [NPWM-1:0] pwm_vec();
    for (int c = 0; c < NPWM; c++) pwm_vec[c] = m_pwm[c];
  endfunction
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("pwm", pwm, pwm_vec());
    check("cmd_done", cmd_done, exp_done);
    check("param_write", param_write, exp_pw);
    if (exp_pw) check("param_data", param_data, exp_pd);
    systime = systime + 1;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc();
  endtask
  task automatic send_config(input int c, input int unsigned per, input int unsigned on,
                             input bit [1:0] fl, input int unsigned dur);
    cmd_ready = 1; cmd = 8'd2; arg_data = c; cyc();
    cmd_ready = 1'($urandom); cmd = 8'($urandom); arg_data = per; cyc();
    arg_data = on; cyc();
    arg_data = {30'b0, fl}; cyc();
    cmd_ready = 0;
    arg_data = dur; c_per = per; c_on = on; c_fl = fl; c_dur = dur; ev_cfg = c; exp_done = 1;
    cyc();
    ev_cfg = -1; exp_done = 0;
  endtask
  task automatic send_sched(input int c, input int unsigned t, input int unsigned on);
    cmd_ready = 1; cmd = 8'd3; arg_data = c; cyc();
    cmd_ready = 0; arg_data = t; cyc();
    arg_data = on; s_time = t; s_on = on; ev_sch = c; exp_done = 1;
    cyc();
    ev_sch = -1; exp_done = 0;
  endtask
  task automatic send_status(input int c, output logic [31:0] sd);
    cmd_ready = 1; cmd = 8'd4; arg_data = c; cyc();
    cmd_ready = 0; ev_rd = c; exp_pw = 1; exp_done = 1;
    cyc();
    sd = param_data;
    ev_rd = -1; exp_pw = 0; exp_done = 0;
  endtask
  task automatic send_unknown();
    cmd_ready = 1; cmd = 8'($urandom_range(255, 5)); arg_data = $urandom; exp_done = 1;
    cyc();
    cmd_ready = 0; exp_done = 0;
  endtask
  task automatic count_high(input int c, input int n, output int ones);
    ones = 0;
    repeat (n) begin
      cyc();
      ones += int'(pwm[c]);
    end
  endtask
  logic [31:0] sd;
  int ones, rc, rk;
  initial begin
    model_clear();
    idle(2);
    check("rst_pwm", pwm, 0);
    check("rst_done", cmd_done, 0);
    check("rst_pw", param_write, 0);
    check("rst_pd", param_data, 0);
    rst_n = 1;
    idle(3);
    in_rst = 0;
    send_config(0, 10, 3, 2'b00, 0);
    idle(5);
    count_high(0, 20, ones);
    check("ch0_duty3", ones, 6);
    send_sched(0, systime + 50, 7);
    idle(70);
    count_high(0, 20, ones);
    check("ch0_duty7", ones, 14);
    send_status(0, sd);
    check("sched_late0", sd[2], 0);
    check("sched_pend0", sd[1], 0);
    check("sched_on7", sd[31:8], 7);
    send_sched(0, systime - 5, 5);
    idle(2);
    send_status(0, sd);
    check("past_late1", sd[2], 1);
    send_status(0, sd);
    check("past_late_clr", sd[2], 0);
    send_config(1, 8, 4, 2'b01, 100);
    send_sched(1, systime, 2);
    idle(115);
    count_high(1, 16, ones);
    check("timeout_high", ones, 16);
    send_config(2, 6, 1, 2'b00, 0);
    systime = 32'hFFFF_FFF0;
    send_sched(2, 32'h0000_0010, 9);
    idle(4);
    send_status(2, sd);
    check("wrap_pending", sd[1], 1);
    idle(30);
    send_status(2, sd);
    check("wrap_fired", sd[1], 0);
    check("wrap_late0", sd[2], 0);
    send_unknown();
    send_config(3, 7, 2, 2'b10, 0);
    idle(4);
    cmd_ready = 1; cmd = 8'd2; arg_data = 5; cyc();
    cmd_ready = 0; arg_data = 9; cyc();
    rst_n = 0;
    #1;
    check("async_pwm", pwm, 0);
    check("async_done", cmd_done, 0);
    in_rst = 1;
    idle(2);
    rst_n = 1;
    idle(3);
    in_rst = 0;
    send_config(4, 5, 2, 2'b10, 0);
    idle(12);
    repeat (150) begin
      rc = $urandom_range(NPWM - 1, 0);
      rk = $urandom_range(4, 0);
      if ($urandom_range(9, 0) == 0) systime = $urandom;
      case (rk)
        0, 1: send_config(rc, $urandom_range(20, 0), $urandom_range(24, 0), 2'($urandom),
                          ($urandom_range(1, 0) == 1) ? $urandom_range(40, 1) : 0);
        2: send_sched(rc, systime + $urandom_range(60, 0) - 20, $urandom_range(24, 0));
        3: send_status(rc, sd);
        default: send_unknown();
      endcase
      idle($urandom_range(6, 0));
    end
    idle(50);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
